// File: rtl/sensor_sample_feeder_pkg.sv
// sensor_feeder_pkg: shared types and defaults for the sensor sample feeder.
// Holds the issue FSM state enum, default sizing and the drop counter ceiling.
package sensor_feeder_pkg;

  typedef enum logic {
    IDLE,
    HOLD
  } feeder_state_e;

  localparam int          DEF_DEPTH        = 8;
  localparam int          DEF_ISSUE_CYCLES = 6;
  localparam logic [15:0] DROP_MAX         = 16'hFFFF;

endpackage

// File: rtl/sensor_sample_feeder_if.sv
// sensor_sample_feeder_if: sensor push side, checker issue side and status.
// master: drives s_data/s_valid/flush; slave: drives det_*, fifo_level, drop_count.
interface sensor_sample_feeder_if
  import sensor_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) ();

  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   flush;
  logic [7:0]             det_data;
  logic                   det_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]            drop_count;

  modport master (
    output s_data, s_valid, flush,
    input  det_data, det_valid, fifo_level, drop_count
  );

  modport slave (
    input  s_data, s_valid, flush,
    output det_data, det_valid, fifo_level, drop_count
  );

endinterface

// File: rtl/sensor_sample_feeder_fifo.sv
// sample_fifo: DEPTH x 8 circular buffer with head shown combinationally.
// Ports: push_i/pop_i/flush_i, data_i, data_o (head), full_o, empty_o, level_o.
module sample_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/sensor_sample_feeder.sv
// sensor_sample_feeder: buffers unstallable sensor samples, issues one per period.
// Ports: clk, reset (async active-low), bus (slave: sensor in, checker out, status).
module sensor_sample_feeder
  import sensor_feeder_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ISSUE_CYCLES = DEF_ISSUE_CYCLES,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(ISSUE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  sensor_sample_feeder_if.slave bus
);

  feeder_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    det_data_q;
  logic          det_valid_q;
  logic [15:0]   drop_q;
  logic [15:0]   drop_d;

  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [LW-1:0] level;

  // A pop frees a slot on the same edge, so a full FIFO still takes the write.
  assign pop  = (state_q == IDLE) && !empty && !bus.flush;
  assign push = bus.s_valid && (!full || pop) && !bus.flush;
  assign drop = bus.s_valid && full && !pop && !bus.flush;

  sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(bus.flush),
    .data_i (bus.s_data),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      det_data_q  <= '0;
      det_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      det_data_q  <= '0;
      det_valid_q <= 1'b0;
    end else begin
      det_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            det_data_q  <= head;
            det_valid_q <= 1'b1;
            cnt_q       <= CW'(ISSUE_CYCLES - 1);
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != DROP_MAX)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign bus.det_data   = det_data_q;
  assign bus.det_valid  = det_valid_q;
  assign bus.fifo_level = level;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_sensor_sample_feeder.sv
// tb_sensor_sample_feeder: directed vectors against hand-computed expectations.
// Drives and samples on the falling edge; one check task counts every compare.
module tb_sensor_sample_feeder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  sensor_sample_feeder_if #(.DEPTH(8)) bus ();

  sensor_sample_feeder #(
    .DEPTH       (8),
    .ISSUE_CYCLES(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] stim [int];
  int         pcyc [$];
  logic [7:0] pdat [$];
  logic [7:0] exp_q [$];
  int         maxlvl;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the falling edge of relative cycle 0; returns at cycle ncyc.
  task automatic run(input int ncyc);
    pcyc.delete();
    pdat.delete();
    maxlvl = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (bus.det_valid) begin
        pcyc.push_back(c);
        pdat.push_back(bus.det_data);
      end
      if (int'(bus.fifo_level) > maxlvl) maxlvl = int'(bus.fifo_level);
      bus.s_valid = stim.exists(c);
      bus.s_data  = stim.exists(c) ? stim[c] : 8'h00;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  // Pulses expected at cycles first, first+7, ... carrying exp_q in order.
  task automatic chk_pulses(input string tag, input int first);
    chk({tag, "_npulse"}, pcyc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pcyc.size(); i++) begin
      chk({tag, "_pcyc"}, pcyc[i], first + 7 * i);
      chk({tag, "_pdat"}, pdat[i], exp_q[i]);
    end
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.flush   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.det_data, 8'h00);
    chk("rst_valid", bus.det_valid, 1'b0);
    chk("rst_level", bus.fifo_level, 4'd0);
    chk("rst_drop", bus.drop_count, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single sample
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAB;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    chk("one_lvl1", bus.fifo_level, 4'd1);
    chk("one_v1", bus.det_valid, 1'b0);
    @(negedge clk);
    chk("one_v2", bus.det_valid, 1'b1);
    chk("one_d2", bus.det_data, 8'hAB);
    chk("one_lvl2", bus.fifo_level, 4'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("one_vhold", bus.det_valid, 1'b0);
      chk("one_dhold", bus.det_data, 8'hAB);
    end
    @(negedge clk);
    chk("one_lvl_end", bus.fifo_level, 4'd0);

    // Burst of 8, in-order issue, pointers wrap
    stim.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      stim[i] = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
    end
    run(60);
    chk_pulses("burst", 2);
    chk("burst_drop", bus.drop_count, 16'd0);

    // Overflow: 12 more while the first issue holds
    stim.delete();
    exp_q.delete();
    stim[0] = 8'h10;
    exp_q.push_back(8'h10);
    for (int i = 0; i < 12; i++) stim[2 + i] = 8'(8'h20 + i);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h20 + i));
    run(75);
    chk_pulses("ovf", 2);
    chk("ovf_peak", maxlvl, 8);
    chk("ovf_drop", bus.drop_count, 16'd3);

    // Write into a full FIFO on the popping edge
    stim.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) stim[i] = 8'(8'h30 + i);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    run(15);
    chk_pulses("full", 2);
    chk("full_lvl15", bus.fifo_level, 4'd8);
    chk("full_v15", bus.det_valid, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3A;
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("full_lvl16", bus.fifo_level, 4'd8);
    chk("full_v16", bus.det_valid, 1'b1);
    chk("full_d16", bus.det_data, 8'h32);
    chk("full_drop", bus.drop_count, 16'd3);

    // Flush while full with a sample offered: no write, no drop
    bus.flush   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.s_valid = 1'b0;
    chk("fl1_lvl", bus.fifo_level, 4'd0);
    chk("fl1_data", bus.det_data, 8'h00);
    chk("fl1_valid", bus.det_valid, 1'b0);
    chk("fl1_drop", bus.drop_count, 16'd3);
    repeat (2) @(negedge clk);

    // Flush during HOLD with 4 queued
    stim.delete();
    stim[0] = 8'h40;
    for (int i = 1; i < 5; i++) stim[i] = 8'(8'h40 + i);
    run(5);
    chk("fl2_lvl_pre", bus.fifo_level, 4'd4);
    chk("fl2_data_pre", bus.det_data, 8'h40);
    bus.flush   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.s_valid = 1'b0;
    chk("fl2_lvl", bus.fifo_level, 4'd0);
    chk("fl2_data", bus.det_data, 8'h00);
    chk("fl2_valid", bus.det_valid, 1'b0);
    chk("fl2_drop", bus.drop_count, 16'd3);
    stim.delete();
    exp_q.delete();
    run(10);
    chk_pulses("fl2_quiet", 0);
    chk("fl2_lvl_end", bus.fifo_level, 4'd0);

    // Saturate the drop counter
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    for (int i = 0; i < 80000 && bus.drop_count != 16'hFFFF; i++)
      @(negedge clk);
    chk("sat_reach", bus.drop_count, 16'hFFFF);
    repeat (14) @(negedge clk);
    chk("sat_hold", bus.drop_count, 16'hFFFF);
    chk("sat_lvl", bus.fifo_level, 4'd8);

    // Async reset in the middle of an issue
    for (int i = 0; i < 10 && !bus.det_valid; i++) @(negedge clk);
    chk("mid_valid", bus.det_valid, 1'b1);
    chk("mid_data", bus.det_data, 8'h5A);
    bus.s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("ar_data", bus.det_data, 8'h00);
    chk("ar_valid", bus.det_valid, 1'b0);
    chk("ar_level", bus.fifo_level, 4'd0);
    chk("ar_drop", bus.drop_count, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_valid", bus.det_valid, 1'b0);
    chk("post_level", bus.fifo_level, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
